// File: rtl/wb_stage_grf.sv
// Writeback stage: decodes the WB instruction, commits to the 32x32 GPR file, serves two bypassed read ports.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_grf #(
    parameter logic [31:0] PC_RESET  = 32'h00003000,
    parameter int          GRF_DEPTH = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] RD_WB,
    input  logic [31:0] AO_WB,
    input  logic [31:0] Instr_WB,
    input  logic [31:0] Pc_WB,
    input  logic [31:0] HI_WB,
    input  logic [31:0] LO_WB,
    input  logic [31:0] cp0_WB,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [4:0]  A3_WB,
    output logic [31:0] WD_WB,
    output logic        WE_WB,
    output logic [31:0] Pc_RET
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] Retire_Cnt
`endif
);

    logic [31:0] grf_r [GRF_DEPTH];
    logic [31:0] pc_ret_r;
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic        dec_we_s;
    logic [4:0]  dec_a3_s;
    logic [31:0] dec_wd_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] pc8_s;

    assign op_s    = Instr_WB[31:26];
    assign rs_s    = Instr_WB[25:21];
    assign rt_s    = Instr_WB[20:16];
    assign rd_s    = Instr_WB[15:11];
    assign funct_s = Instr_WB[5:0];
    assign pc8_s   = Pc_WB + 32'd8;
    assign half_s  = AO_WB[1] ? RD_WB[31:16] : RD_WB[15:0];

    // Byte lane selection for lb/lbu
    always_comb begin
        byte_s = 8'd0;
        case (AO_WB[1:0])
            2'd0:    byte_s = RD_WB[7:0];
            2'd1:    byte_s = RD_WB[15:8];
            2'd2:    byte_s = RD_WB[23:16];
            2'd3:    byte_s = RD_WB[31:24];
            default: byte_s = 8'd0;
        endcase
    end

    // Instruction decode into destination / data candidates
    always_comb begin
        dec_we_s = 1'b0;
        dec_a3_s = 5'd0;
        dec_wd_s = 32'd0;
        case (op_s)
            6'b000000: begin
                case (funct_s)
                    6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b000100,
                    6'b000110, 6'b000111: begin
                        dec_we_s = 1'b1; dec_a3_s = rd_s; dec_wd_s = AO_WB;
                    end
                    6'b001001: begin dec_we_s = 1'b1; dec_a3_s = rd_s; dec_wd_s = pc8_s; end
                    6'b010000: begin dec_we_s = 1'b1; dec_a3_s = rd_s; dec_wd_s = HI_WB; end
                    6'b010010: begin dec_we_s = 1'b1; dec_a3_s = rd_s; dec_wd_s = LO_WB; end
                    default: begin dec_we_s = 1'b0; end
                endcase
            end
            6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b001010, 6'b001011: begin
                dec_we_s = 1'b1; dec_a3_s = rt_s; dec_wd_s = AO_WB;
            end
            6'b100011: begin dec_we_s = 1'b1; dec_a3_s = rt_s; dec_wd_s = RD_WB; end
            6'b100000: begin dec_we_s = 1'b1; dec_a3_s = rt_s; dec_wd_s = {{24{byte_s[7]}}, byte_s}; end
            6'b100100: begin dec_we_s = 1'b1; dec_a3_s = rt_s; dec_wd_s = {24'd0, byte_s}; end
            6'b100001: begin dec_we_s = 1'b1; dec_a3_s = rt_s; dec_wd_s = {{16{half_s[15]}}, half_s}; end
            6'b100101: begin dec_we_s = 1'b1; dec_a3_s = rt_s; dec_wd_s = {16'd0, half_s}; end
            6'b000011: begin dec_we_s = 1'b1; dec_a3_s = 5'd31; dec_wd_s = pc8_s; end
            6'b010000: begin
                if (rs_s == 5'd0) begin
                    dec_we_s = 1'b1; dec_a3_s = rt_s; dec_wd_s = cp0_WB;
                end else begin
                    dec_we_s = 1'b0;
                end
            end
            default: begin dec_we_s = 1'b0; end
        endcase
    end

    // Writes to $0 are dropped entirely so the forwarding triple stays clean
    always_comb begin
        if (dec_we_s && (dec_a3_s != 5'd0)) begin
            WE_WB = 1'b1;
            A3_WB = dec_a3_s;
            WD_WB = dec_wd_s;
        end else begin
            WE_WB = 1'b0;
            A3_WB = 5'd0;
            WD_WB = 32'd0;
        end
    end

    // Register file commit and retired-PC tracking
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < GRF_DEPTH; i++) begin
                grf_r[i] <= 32'd0;
            end
            pc_ret_r <= PC_RESET;
        end else if (WE_WB) begin
            grf_r[A3_WB] <= WD_WB;
            pc_ret_r     <= Pc_WB;
        end
    end

    assign Pc_RET = pc_ret_r;

    // Read port 1 with WB write-through
    always_comb begin
        if (A1 == 5'd0) begin
            RD1 = 32'd0;
        end else if (WE_WB && (A1 == A3_WB)) begin
            RD1 = WD_WB;
        end else begin
            RD1 = grf_r[A1];
        end
    end

    // Read port 2 with WB write-through
    always_comb begin
        if (A2 == 5'd0) begin
            RD2 = 32'd0;
        end else if (WE_WB && (A2 == A3_WB)) begin
            RD2 = WD_WB;
        end else begin
            RD2 = grf_r[A2];
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_r;

    // Count every non-nop instruction reaching WB, writing or not
    always_ff @(posedge Clk) begin
        if (Reset) begin
            retire_cnt_r <= 32'd0;
        end else if (Instr_WB != 32'd0) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end
    end

    assign Retire_Cnt = retire_cnt_r;
`endif

endmodule

// File: tb/tb_wb_stage_grf.sv
// Randomized bench for wb_stage_grf against an instruction-level reference model.
module tb_wb_stage_grf;

    logic        Clk;
    logic        Reset;
    logic [31:0] RD_WB, AO_WB, Instr_WB, Pc_WB, HI_WB, LO_WB, cp0_WB;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, WD_WB, Pc_RET;
    logic [4:0]  A3_WB;
    logic        WE_WB;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] Retire_Cnt;
`endif

    wb_stage_grf dut (
        .Clk(Clk), .Reset(Reset), .RD_WB(RD_WB), .AO_WB(AO_WB), .Instr_WB(Instr_WB),
        .Pc_WB(Pc_WB), .HI_WB(HI_WB), .LO_WB(LO_WB), .cp0_WB(cp0_WB), .A1(A1), .A2(A2),
        .RD1(RD1), .RD2(RD2), .A3_WB(A3_WB), .WD_WB(WD_WB), .WE_WB(WE_WB), .Pc_RET(Pc_RET)
`ifdef WB_RETIRE_CNT_EN
        , .Retire_Cnt(Retire_Cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state
    logic [31:0] gpr_m [32];
    logic [31:0] pc_ret_m;
    logic [31:0] cnt_m;

    typedef struct packed {
        logic        dw;   // instruction writes some register (maybe $0)
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } wb_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] funct, input logic [4:0] rs, rt, rd);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instruction semantics straight from the ISA table
    function automatic wb_t ref_decode(input logic [31:0] ins, ao, rdw, pc, hi, lo, cp0);
        wb_t r;
        logic [5:0] op, fn;
        logic [31:0] b, h;
        op = ins[31:26];
        fn = ins[5:0];
        b  = (rdw >> (8 * ao[1:0])) & 32'h000000FF;
        h  = (rdw >> (16 * ao[1])) & 32'h0000FFFF;
        r  = '0;
        if (op == 6'h00) begin
            if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                           6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
                r.dw = 1'b1; r.a3 = ins[15:11]; r.wd = ao;
            end else if (fn == 6'h09) begin
                r.dw = 1'b1; r.a3 = ins[15:11]; r.wd = pc + 32'd8;
            end else if (fn == 6'h10) begin
                r.dw = 1'b1; r.a3 = ins[15:11]; r.wd = hi;
            end else if (fn == 6'h12) begin
                r.dw = 1'b1; r.a3 = ins[15:11]; r.wd = lo;
            end
        end else if (op inside {6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h0a, 6'h0b}) begin
            r.dw = 1'b1; r.a3 = ins[20:16]; r.wd = ao;
        end else if (op == 6'h23) begin
            r.dw = 1'b1; r.a3 = ins[20:16]; r.wd = rdw;
        end else if (op == 6'h20) begin
            r.dw = 1'b1; r.a3 = ins[20:16]; r.wd = b[7] ? (b | 32'hFFFFFF00) : b;
        end else if (op == 6'h24) begin
            r.dw = 1'b1; r.a3 = ins[20:16]; r.wd = b;
        end else if (op == 6'h21) begin
            r.dw = 1'b1; r.a3 = ins[20:16]; r.wd = h[15] ? (h | 32'hFFFF0000) : h;
        end else if (op == 6'h25) begin
            r.dw = 1'b1; r.a3 = ins[20:16]; r.wd = h;
        end else if (op == 6'h03) begin
            r.dw = 1'b1; r.a3 = 5'd31; r.wd = pc + 32'd8;
        end else if (op == 6'h10 && ins[25:21] == 5'd0) begin
            r.dw = 1'b1; r.a3 = ins[20:16]; r.wd = cp0;
        end
        r.we = r.dw && (r.a3 != 5'd0);
        if (!r.we) begin
            r.a3 = 5'd0;
            if (!r.dw) r.wd = 32'd0;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input wb_t w);
        if (a == 5'd0) return 32'd0;
        if (w.we && a == w.a3) return w.wd;
        return gpr_m[a];
    endfunction

    task automatic drive(input logic rst, input logic [31:0] ins, rdw, ao, pc, hi, lo, cp0,
                         input logic [4:0] a1, a2);
        @(negedge Clk);
        Reset = rst; Instr_WB = ins; RD_WB = rdw; AO_WB = ao; Pc_WB = pc;
        HI_WB = hi; LO_WB = lo; cp0_WB = cp0; A1 = a1; A2 = a2;
        #1;
    endtask

    // Compare combinational outputs, clock the edge, then update and compare state
    task automatic check_and_clock();
        wb_t w;
        w = ref_decode(Instr_WB, AO_WB, RD_WB, Pc_WB, HI_WB, LO_WB, cp0_WB);
        chk("we", {31'd0, WE_WB}, {31'd0, w.we});
        chk("a3", {27'd0, A3_WB}, {27'd0, w.a3});
        if (w.we || !w.dw) chk("wd", WD_WB, w.wd);
        chk("rd1", RD1, ref_read(A1, w));
        chk("rd2", RD2, ref_read(A2, w));
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 32; i++) gpr_m[i] = 32'd0;
            pc_ret_m = 32'h00003000;
            cnt_m = 32'd0;
        end else begin
            if (w.we) begin
                gpr_m[w.a3] = w.wd;
                pc_ret_m = Pc_WB;
            end
            if (Instr_WB != 32'd0) cnt_m = cnt_m + 32'd1;
        end
        #1;
        chk("pc_ret", Pc_RET, pc_ret_m);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", Retire_Cnt, cnt_m);
`endif
    endtask

    task automatic cycle(input logic rst, input logic [31:0] ins, rdw, ao, pc, hi, lo, cp0,
                         input logic [4:0] a1, a2);
        drive(rst, ins, rdw, ao, pc, hi, lo, cp0, a1, a2);
        check_and_clock();
    endtask

    function automatic logic [31:0] rand_instr(input logic [4:0] rt, rd);
        logic [31:0] k;
        k = $urandom_range(0, 19);
        case (k)
            0: return r_ins(6'h21, 5'd1, 5'd2, rd);
            1: return r_ins(6'h2a, 5'd1, 5'd2, rd);
            2: return r_ins(6'h00, 5'd0, 5'd2, rd);
            3: return r_ins(6'h09, 5'd1, 5'd0, rd);
            4: return r_ins(6'h10, 5'd0, 5'd0, rd);
            5: return r_ins(6'h12, 5'd0, 5'd0, rd);
            6: return i_ins(6'h0d, 5'd1, rt, 16'h1234);
            7: return i_ins(6'h0f, 5'd0, rt, 16'hBEEF);
            8: return i_ins(6'h23, 5'd1, rt, 16'h0);
            9: return i_ins(6'h20, 5'd1, rt, 16'h0);
            10: return i_ins(6'h24, 5'd1, rt, 16'h0);
            11: return i_ins(6'h21, 5'd1, rt, 16'h0);
            12: return i_ins(6'h25, 5'd1, rt, 16'h0);
            13: return {6'h03, 26'h0000400};
            14: return {6'h10, 5'd0, rt, rd, 11'd0};
            15: return i_ins(6'h2b, 5'd1, rt, 16'h4);
            16: return i_ins(6'h04, 5'd1, rt, 16'h8);
            17: return r_ins(6'h18, 5'd1, 5'd2, 5'd0);
            18: return {6'h10, 5'd4, rt, rd, 11'd0};
            default: return (($urandom_range(0, 1) == 0) ? 32'd0 : {6'h3f, 26'h155});
        endcase
    endfunction

    initial begin
        Reset = 1'b1; Instr_WB = 32'd0; RD_WB = 32'd0; AO_WB = 32'd0; Pc_WB = 32'd0;
        HI_WB = 32'd0; LO_WB = 32'd0; cp0_WB = 32'd0; A1 = 5'd0; A2 = 5'd0;
        for (int i = 0; i < 32; i++) gpr_m[i] = 32'hx;
        pc_ret_m = 32'hx;
        cnt_m = 32'd0;

        // Reset then sweep every read address
        cycle(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("pc_ret_reset", Pc_RET, 32'h00003000);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, a[4:0], 5'(31 - a));
            chk("rd1_reset", RD1, 32'd0);
            chk("rd2_reset", RD2, 32'd0);
        end

        // addu $3 with bypass, then stored
        drive(1'b0, r_ins(6'h21, 5'd1, 5'd2, 5'd3), 32'd0, 32'h12345678, 32'h3010, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3);
        chk("addu_bypass", RD1, 32'h12345678);
        check_and_clock();
        chk("addu_pcret", Pc_RET, 32'h3010);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd0);
        chk("addu_stored", RD1, 32'h12345678);
        check_and_clock();

        // Sub-word loads
        drive(1'b0, i_ins(6'h20, 5'd1, 5'd5, 16'h3), 32'h80FF7F01, 32'h00000103, 32'h3014, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        chk("lb_wd", WD_WB, 32'hFFFFFF80);
        check_and_clock();
        drive(1'b0, i_ins(6'h24, 5'd1, 5'd5, 16'h3), 32'h80FF7F01, 32'h00000103, 32'h3018, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        chk("lbu_wd", WD_WB, 32'h00000080);
        check_and_clock();
        drive(1'b0, i_ins(6'h21, 5'd1, 5'd5, 16'h1), 32'h80FF7F01, 32'h00000101, 32'h301c, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        chk("lh_wd", WD_WB, 32'h00007F01);
        check_and_clock();

        // jal and write to $0
        drive(1'b0, {6'h03, 26'h0000400}, 32'd0, 32'd0, 32'h3020, 32'd0, 32'd0, 32'd0, 5'd31, 5'd0);
        chk("jal_a3", {27'd0, A3_WB}, 32'd31);
        chk("jal_wd", WD_WB, 32'h3028);
        check_and_clock();
        drive(1'b0, i_ins(6'h0d, 5'd1, 5'd0, 16'h5), 32'd0, 32'd5, 32'h3024, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("ori0_we", {31'd0, WE_WB}, 32'd0);
        chk("ori0_rd1", RD1, 32'd0);
        check_and_clock();

        // Non-writers leave GPR[7] and Pc_RET alone
        cycle(1'b0, i_ins(6'h0d, 5'd0, 5'd7, 16'h9), 32'd0, 32'd9, 32'h3030, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b0, i_ins(6'h2b, 5'd1, 5'd7, 16'h0), 32'd0, 32'd44, 32'h3034, 32'd0, 32'd0, 32'd0, 5'd7, 5'd0);
        cycle(1'b0, i_ins(6'h04, 5'd7, 5'd7, 16'h4), 32'd0, 32'd7, 32'h3038, 32'd0, 32'd0, 32'd0, 5'd7, 5'd0);
        drive(1'b0, r_ins(6'h18, 5'd7, 5'd7, 5'd0), 32'd0, 32'd7, 32'h303c, 32'd0, 32'd0, 32'd0, 5'd7, 5'd7);
        chk("mult_we", {31'd0, WE_WB}, 32'd0);
        chk("gpr7_held", RD1, 32'd9);
        check_and_clock();
        chk("pcret_held", Pc_RET, 32'h3030);

        // mfc0
        cycle(1'b0, {6'h10, 5'd0, 5'd8, 5'd12, 11'd0}, 32'd0, 32'd0, 32'h3040, 32'd0, 32'd0, 32'h0000DEAD, 5'd0, 5'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 5'd0);
        chk("mfc0_stored", RD1, 32'h0000DEAD);
        check_and_clock();

        // Reset wins over a pending lw; bypass still visible
        cycle(1'b0, i_ins(6'h0d, 5'd0, 5'd4, 16'h1), 32'd0, 32'd77, 32'h3044, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        drive(1'b1, i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'hCAFEF00D, 32'd0, 32'h3048, 32'd0, 32'd0, 32'd0, 5'd4, 5'd4);
        chk("rst_bypass", RD1, 32'hCAFEF00D);
        check_and_clock();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd0);
        chk("rst_gpr4", RD1, 32'd0);
        check_and_clock();

        // Three instructions and a nop
        cycle(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b0, i_ins(6'h0d, 5'd0, 5'd2, 16'h1), 32'd0, 32'd1, 32'h3050, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b0, i_ins(6'h2b, 5'd0, 5'd2, 16'h1), 32'd0, 32'd1, 32'h3054, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'h3058, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b0, r_ins(6'h18, 5'd1, 5'd2, 5'd0), 32'd0, 32'd0, 32'h305c, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt_3", Retire_Cnt, 32'd3);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rt, rd, a1, a2;
            logic [31:0] ins;
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            ins = rand_instr(rt, rd);
            a1 = ($urandom_range(0, 3) == 0) ? ins[20:16] : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? ins[15:11] : 5'($urandom_range(0, 7));
            cycle(($urandom_range(0, 40) == 0), ins, $urandom, $urandom, $urandom & 32'hFFFFFFFC,
                  $urandom, $urandom, $urandom, a1, a2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_stage_grf.md
Name: wb_stage_grf

Overview:
- Writeback end of the MEM/WB pipeline interface. Consumes the registered WB-stage bundle (RD, AO, Instr, Pc, HI, LO, cp0) and decodes Instr_WB into a destination register, a write enable and write data.
- Commits the result into the 32x32 general register file on the rising clock edge.
- Serves the ID stage two combinational read ports with WB write-through bypass.
- Exports the WB write triple for the forwarding unit.

Parameters:
- PC_RESET, 32'h00003000, value of the retired-PC output after reset.
- GRF_DEPTH, 32, number of GPRs. Fixed at 32; $0 is hardwired to zero.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- RD_WB  in  32  memory read word (aligned word at AO[31:2])
- AO_WB  in  32  ALU result / memory address
- Instr_WB  in  32  instruction in WB (0 = nop)
- Pc_WB  in  32  PC of instruction in WB
- HI_WB  in  32  HI value
- LO_WB  in  32  LO value
- cp0_WB  in  32  CP0 read data
- A1  in  5  ID read address 1
- A2  in  5  ID read address 2
- RD1  out  32  read data 1
- RD2  out  32  read data 2
- A3_WB  out  5  decoded destination register (0 when no write)
- WD_WB  out  32  decoded write data
- WE_WB  out  1  write enable (A3_WB!=0 and instruction writes)
- Pc_RET  out  32  PC of last retired writing instruction

Behaviour:
- Reset (Clk edge with Reset=1): GPR[1..31] <= 0; Pc_RET <= PC_RESET; no GRF write that cycle even if WE_WB=1. GPR[0] always reads 0.
- Destination and data decode, purely combinational from Instr_WB:
  - R-type ALU (addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav) -> rd, AO.
  - jalr -> rd, Pc_WB+8.
  - mfhi -> rd, HI. mflo -> rd, LO.
  - addiu, andi, ori, xori, lui, slti, sltiu -> rt, AO.
  - lw -> rt, RD.
  - lb/lbu -> rt, byte RD[8*AO[1:0]+7 -: 8], sign-/zero-extended.
  - lh/lhu -> rt, half selected by AO[1] (AO[0] ignored), sign-/zero-extended.
  - jal -> 31, Pc_WB+8.
  - mfc0 (op 010000, rs 00000) -> rt, cp0.
  - All others (stores, branches, j, mult/div, mthi/mtlo, mtc0, eret, nop, undefined) -> A3_WB=0, WE_WB=0, WD_WB=0.
- WE_WB = decoded write AND A3_WB!=0. A write to $0 yields A3_WB=0, WE_WB=0.
- Commit: on posedge Clk with Reset=0 and WE_WB=1: GPR[A3_WB] <= WD_WB and Pc_RET <= Pc_WB. Otherwise both hold. Latency is 1 cycle from WB presentation to storage.
- Read ports: RD1 = (A1==0) ? 0 : (WE_WB && A1==A3_WB) ? WD_WB : GPR[A1]. RD2 likewise. Bypass gives same-cycle visibility of the WB result to ID.
- Simultaneous: A1==A2==A3_WB -> both ports bypass. Reset asserted with WE_WB=1 -> reset wins, bypass still drives RD1/RD2 combinationally.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Extra output Retire_Cnt [31:0], cleared on Reset.
  - Increments by 1 on every non-reset edge where Instr_WB!=0, whether or not it writes.
  - Wraps 32'hFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then read all A1/A2 0..31 -> RD1=RD2=0, Pc_RET=32'h00003000.
- addu $3 (rd=3) with AO=32'h12345678, Pc=32'h3010 -> same cycle RD1(A1=3)=32'h12345678 via bypass; next cycle stored, Pc_RET=32'h3010.
- lb rt=5, RD=32'h80FF7F01, AO[1:0]=2'b11 -> WD=32'hFFFFFF80. lbu same -> 32'h00000080. lh AO[1]=0 -> 32'h00007F01.
- jal Pc=32'h3020 -> A3=31, WD=32'h3028. ori rt=0 AO=5 -> WE=0, RD1(A1=0)=0.
- sw/beq/mult in WB after GPR[7]=9 -> WE=0, GPR[7] still 9, Pc_RET unchanged. mfc0 rt=8 cp0=32'hDEAD -> GPR[8]=32'hDEAD.
- Reset asserted while WB holds lw rt=4 -> GPR[4]=0 after edge. With WB_RETIRE_CNT_EN: 3 non-nop instrs plus 1 nop -> Retire_Cnt=3.
